dram_dq_pad_seq: RTL and testbench
==================================

Name: dram_dq_pad_seq

Overview:
- Per-byte-lane sequencer for the DQ pad slice.
- Accepts read/write burst commands from the DRAM controller.
- Drives the pad slice's dram_io_drive_enable, dram_io_pad_enable, dqs_read and pad_pos_cnt/pad_neg_cnt capture pointers with correct latency, preamble/postamble and bus turnaround.
- Returns a data-request strobe for writes and a delayed read-valid/pointer stream for the core.

Parameters:
- WR_LAT, 2, cycles from write accept to first write-data cycle minus 1; legal range 1..15.
- RD_LAT, 4, cycles from read accept to first read-capture cycle minus 1; legal range 1..15.
- RD_CAP_DLY, 2, cycles from capture cycle to rd_data_valid; legal range 1..7.
- TURN_CYC, 2, idle cycles forced after every read burst; legal range 0..7.

Ports:
- clk  in  1  core clock, all state on rising edge
- arst  in  1  asynchronous reset, active high
- cmd_valid  in  1  command request
- cmd_ready  out  1  sequencer can accept; high only in IDLE
- cmd_wr  in  1  1=write burst, 0=read burst; sampled on accept
- burst_length_four  in  1  1=BL4 (2 data cycles), 0=BL8 (4 data cycles); sampled on accept
- dram_io_drive_enable  out  1  DQ output driver enable
- dram_io_pad_enable  out  1  receiver/ODT enable for reads
- dqs_read  out  1  read-capture window
- pad_pos_cnt  out  2  posedge capture entry pointer
- pad_neg_cnt  out  2  negedge capture entry pointer
- wr_data_req  out  1  upstream must present data_pos/data_neg this cycle
- rd_data_valid  out  1  captured read entry ready for core
- rd_data_ptr  out  2  entry index qualified by rd_data_valid
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, immediate, including mid-burst): state=IDLE; all outputs 0 except cmd_ready=1; pointers 0; delay line cleared.
- Accept occurs when cmd_valid && cmd_ready. cmd_wr and burst_length_four are latched on accept; later changes mid-burst are ignored.
- N = 2 if BL4, else 4.
- States: IDLE, WLAT, WDATA, WPOST, RLAT, RDATA, TURN.
- IDLE: on accept, go to WLAT if write, else RLAT. Load lat counter.
- WLAT: WR_LAT cycles, then WDATA. dram_io_drive_enable is high in the last WLAT cycle (preamble).
- WDATA: N cycles. drive_enable=1 and wr_data_req=1. Then WPOST.
- WPOST: 1 cycle, drive_enable=1 (postamble), then IDLE. No extra gap before the next command.
- RLAT: RD_LAT cycles. dram_io_pad_enable=1. Then RDATA.
- RDATA: N cycles. pad_enable=1 and dqs_read=1. pad_pos_cnt increments mod 4 at the end of each RDATA cycle. pad_neg_cnt takes the old pad_pos_cnt value one cycle later, i.e. it lags by one cycle.
- After RDATA: go to TURN if TURN_CYC>0, else IDLE.
- TURN: TURN_CYC cycles; cmd_ready=0; then IDLE.
- Pointers are free-running across bursts and wrap 3->0. They are cleared only by reset.
- rd_data_valid/rd_data_ptr: {dqs_read, pad_pos_cnt} delayed exactly RD_CAP_DLY cycles. This continues through TURN/IDLE until drained.
- Counters are 4 bits wide and saturate-free; the legal ranges above guarantee no overflow.
- All outputs are registered, with no combinational path from cmd_valid to any output, except cmd_ready, which is derived from the state register only.
- A command presented in the cycle the FSM enters IDLE is accepted that cycle.

Decomposition:
- Package dram_dq_seq_pkg:
  - state enum
  - BL4_CYC=2, BL8_CYC=4
  - PTR_W=2, LAT_W=4
- Sub-module dram_dq_rd_cap_dly: parameterised shift delay line (depth RD_CAP_DLY, width 1+PTR_W) with async-reset clear.
- The FSM, latency counter and pointers live in the top module.

Test Plan:
- BL4 write, defaults, accept cycle 0 ->
  - WLAT 1-2, WDATA 3-4, WPOST 5
  - drive_enable high 2-5
  - wr_data_req high 3-4
  - cmd_ready high again at cycle 6
  - pointers unchanged
- BL8 read at cycle 0 ->
  - pad_enable high 1-8
  - dqs_read high 5-8 with pad_pos_cnt 0,1,2,3; pad_neg_cnt 0,1,2,3 on cycles 6-9
  - rd_data_valid 7-10 with ptr 0-3
  - TURN 9-10, cmd_ready at 11, pad_pos_cnt back to 0
- BL4 read then BL4 write held on cmd_valid ->
  - write accepted exactly at IDLE entry (read accept 0, RDATA 5-6, TURN 7-8, write accepted cycle 9)
  - first drive_enable at cycle 11
- Write then read back-to-back ->
  - read accepted the cycle after WPOST
  - drive_enable and pad_enable never high in the same cycle
- Two BL4 reads, TURN_CYC=0 -> second read's pointers are 2,3 (no reset between bursts); rd_data_ptr sequence 0,1,2,3.
- arst asserted during RDATA of BL8 (cycle 6) ->
  - all enables, dqs_read, rd_data_valid and pointers 0 immediately
  - cmd_ready=1 and busy=0 after release
  - next read starts from ptr 0
- burst_length_four toggled mid-burst -> burst length unchanged.

Source files
------------

// File: rtl/dram_dq_pad_seq_pkg.sv
// Shared types and widths for the DQ pad-slice sequencer.
// State encoding, burst data-cycle counts and counter/pointer widths.
package dram_dq_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WLAT,
    WDATA,
    WPOST,
    RLAT,
    RDATA,
    TURN
  } seq_state_t;

  localparam int BL4_CYC = 2;
  localparam int BL8_CYC = 4;
  localparam int PTR_W   = 2;
  localparam int LAT_W   = 4;

  // Counter reload for the last data cycle of a burst (counts down to 0).
  function automatic logic [LAT_W-1:0] burst_last(input logic bl4);
    return bl4 ? LAT_W'(BL4_CYC - 1) : LAT_W'(BL8_CYC - 1);
  endfunction

endpackage

// File: rtl/dram_dq_pad_seq_if.sv
// Command handshake plus pad-slice / core-side strobes of one byte lane.
// master = controller/core side, slave = sequencer.
interface dram_dq_pad_seq_if;
  import dram_dq_seq_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_wr;
  logic             burst_length_four;
  logic             dram_io_drive_enable;
  logic             dram_io_pad_enable;
  logic             dqs_read;
  logic [PTR_W-1:0] pad_pos_cnt;
  logic [PTR_W-1:0] pad_neg_cnt;
  logic             wr_data_req;
  logic             rd_data_valid;
  logic [PTR_W-1:0] rd_data_ptr;
  logic             busy;

  modport master (
    output cmd_valid, cmd_wr, burst_length_four,
    input  cmd_ready, dram_io_drive_enable, dram_io_pad_enable, dqs_read,
           pad_pos_cnt, pad_neg_cnt, wr_data_req, rd_data_valid, rd_data_ptr, busy
  );

  modport slave (
    input  cmd_valid, cmd_wr, burst_length_four,
    output cmd_ready, dram_io_drive_enable, dram_io_pad_enable, dqs_read,
           pad_pos_cnt, pad_neg_cnt, wr_data_req, rd_data_valid, rd_data_ptr, busy
  );

endinterface

// File: rtl/dram_dq_rd_cap_dly.sv
// Fixed-depth shift delay for the read-capture {valid, ptr} stream; DEPTH cycles latency.
// No backpressure: shifts every cycle, cleared by async reset.
module dram_dq_rd_cap_dly #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/dram_dq_pad_seq.sv
// Byte-lane DQ pad sequencer: burst FSM driving pad enables, capture pointers and data strobes.
// Outputs registered one cycle after the state decision; accepts a command only in IDLE.
module dram_dq_pad_seq #(
  parameter int WR_LAT     = 2,
  parameter int RD_LAT     = 4,
  parameter int RD_CAP_DLY = 2,
  parameter int TURN_CYC   = 2
) (
  input  logic                    clk,
  input  logic                    arst,
  dram_dq_pad_seq_if.slave        bus
);
  import dram_dq_seq_pkg::*;

  seq_state_t       state;
  logic [LAT_W-1:0] cnt;
  logic             bl4_q;
  logic             drv_q;
  logic             pad_q;
  logic             dqs_q;
  logic             req_q;
  logic [PTR_W-1:0] pos_q;
  logic [PTR_W-1:0] neg_q;
  logic [PTR_W:0]   cap_out;

  // Each branch sets the outputs for the cycle the FSM is about to enter.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
      cnt   <= '0;
      bl4_q <= 1'b0;
      drv_q <= 1'b0;
      pad_q <= 1'b0;
      dqs_q <= 1'b0;
      req_q <= 1'b0;
      pos_q <= '0;
      neg_q <= '0;
    end else begin
      neg_q <= pos_q;
      if (state == RDATA) pos_q <= pos_q + PTR_W'(1);

      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bl4_q <= bus.burst_length_four;
            if (bus.cmd_wr) begin
              state <= WLAT;
              cnt   <= LAT_W'(WR_LAT - 1);
              drv_q <= (WR_LAT == 1);
            end else begin
              state <= RLAT;
              cnt   <= LAT_W'(RD_LAT - 1);
              pad_q <= 1'b1;
            end
          end
        end
        WLAT: begin
          if (cnt == '0) begin
            state <= WDATA;
            cnt   <= burst_last(bl4_q);
            drv_q <= 1'b1;
            req_q <= 1'b1;
          end else begin
            cnt   <= cnt - LAT_W'(1);
            drv_q <= (cnt == LAT_W'(1));
          end
        end
        WDATA: begin
          if (cnt == '0) begin
            state <= WPOST;
            req_q <= 1'b0;
          end else begin
            cnt <= cnt - LAT_W'(1);
          end
        end
        WPOST: begin
          state <= IDLE;
          drv_q <= 1'b0;
        end
        RLAT: begin
          if (cnt == '0) begin
            state <= RDATA;
            cnt   <= burst_last(bl4_q);
            dqs_q <= 1'b1;
          end else begin
            cnt <= cnt - LAT_W'(1);
          end
        end
        RDATA: begin
          if (cnt == '0) begin
            dqs_q <= 1'b0;
            pad_q <= 1'b0;
            if (TURN_CYC > 0) begin
              state <= TURN;
              cnt   <= LAT_W'(TURN_CYC - 1);
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - LAT_W'(1);
          end
        end
        TURN: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - LAT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  dram_dq_rd_cap_dly #(
    .DEPTH (RD_CAP_DLY),
    .WIDTH (PTR_W + 1)
  ) u_cap_dly (
    .clk  (clk),
    .arst (arst),
    .din  ({dqs_q, pos_q}),
    .dout (cap_out)
  );

  assign bus.cmd_ready            = (state == IDLE);
  assign bus.busy                 = (state != IDLE);
  assign bus.dram_io_drive_enable = drv_q;
  assign bus.dram_io_pad_enable   = pad_q;
  assign bus.dqs_read             = dqs_q;
  assign bus.wr_data_req          = req_q;
  assign bus.pad_pos_cnt          = pos_q;
  assign bus.pad_neg_cnt          = neg_q;
  assign bus.rd_data_valid        = cap_out[PTR_W];
  assign bus.rd_data_ptr          = cap_out[PTR_W-1:0];

endmodule

// File: tb/tb_dram_dq_pad_seq.sv
// Bench for dram_dq_pad_seq: directed timing scenarios plus a randomized run against a
// burst-schedule model (default parameters) and a minimum-latency, no-turnaround instance.
module tb_dram_dq_pad_seq;

  localparam int A_WR   = 2;
  localparam int A_RD   = 4;
  localparam int A_D    = 2;
  localparam int A_TURN = 2;
  localparam int NT     = 32;
  localparam int NR     = 600;
  localparam int MAXC   = NR + 40;

  logic clk;
  logic arst;
  int   n_vec;
  int   n_err;

  dram_dq_pad_seq_if ifa ();
  dram_dq_pad_seq_if ifb ();

  dram_dq_pad_seq #(.WR_LAT(A_WR), .RD_LAT(A_RD), .RD_CAP_DLY(A_D), .TURN_CYC(A_TURN)) dut_a (
    .clk(clk), .arst(arst), .bus(ifa));

  dram_dq_pad_seq #(.WR_LAT(1), .RD_LAT(1), .RD_CAP_DLY(1), .TURN_CYC(0)) dut_b (
    .clk(clk), .arst(arst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // per-cycle traces of dut_a captured by run_cmds
  logic       tr_drv [NT];
  logic       tr_pad [NT];
  logic       tr_dqs [NT];
  logic       tr_req [NT];
  logic       tr_rdy [NT];
  logic       tr_busy[NT];
  logic       tr_vld [NT];
  logic [1:0] tr_pos [NT];
  logic [1:0] tr_neg [NT];
  logic [1:0] tr_ptr [NT];
  int         acc_cyc[2];
  int         n_acc;

  // burst schedule model for the randomized run
  bit m_drv[MAXC];
  bit m_req[MAXC];
  bit m_pad[MAXC];
  bit m_dqs[MAXC];
  int m_pos[MAXC];

  task automatic do_reset();
    arst = 1'b1;
    ifa.cmd_valid = 1'b0; ifa.cmd_wr = 1'b0; ifa.burst_length_four = 1'b0;
    ifb.cmd_valid = 1'b0; ifb.cmd_wr = 1'b0; ifb.burst_length_four = 1'b0;
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
  endtask

  // Cycle 0 presents command 0; command 1 (optional) is held from the cycle after
  // command 0 is accepted until it is itself accepted. wiggle toggles cmd_wr and
  // burst_length_four every cycle in which no command is presented.
  task automatic run_cmds(input int ncyc, input bit wr0, input bit bl0, input bit has2,
                          input bit wr1, input bit bl1, input bit wiggle);
    bit acc_now;
    n_acc = 0;
    acc_cyc[0] = -1;
    acc_cyc[1] = -1;
    ifa.cmd_valid = 1'b1; ifa.cmd_wr = wr0; ifa.burst_length_four = bl0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      tr_drv[c]  = ifa.dram_io_drive_enable;
      tr_pad[c]  = ifa.dram_io_pad_enable;
      tr_dqs[c]  = ifa.dqs_read;
      tr_req[c]  = ifa.wr_data_req;
      tr_rdy[c]  = ifa.cmd_ready;
      tr_busy[c] = ifa.busy;
      tr_vld[c]  = ifa.rd_data_valid;
      tr_pos[c]  = ifa.pad_pos_cnt;
      tr_neg[c]  = ifa.pad_neg_cnt;
      tr_ptr[c]  = ifa.rd_data_ptr;
      acc_now = ifa.cmd_valid && ifa.cmd_ready;
      if (acc_now && n_acc < 2) begin
        acc_cyc[n_acc] = c;
        n_acc++;
      end
      @(posedge clk);
      #1;
      if (acc_now) begin
        if (n_acc == 1 && has2) begin
          ifa.cmd_wr = wr1; ifa.burst_length_four = bl1;
        end else begin
          ifa.cmd_valid = 1'b0;
        end
      end
      if (wiggle && !ifa.cmd_valid) begin
        ifa.cmd_wr = ~ifa.cmd_wr;
        ifa.burst_length_four = ~ifa.burst_length_four;
      end
    end
    ifa.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    arst = 1'b1;
    ifa.cmd_valid = 1'b0; ifa.cmd_wr = 1'b0; ifa.burst_length_four = 1'b0;
    ifb.cmd_valid = 1'b0; ifb.cmd_wr = 1'b0; ifb.burst_length_four = 1'b0;
    @(negedge clk);
    got = {ifa.dram_io_drive_enable, ifa.dram_io_pad_enable, ifa.dqs_read, ifa.wr_data_req,
           ifa.rd_data_valid, ifa.busy, ifa.pad_pos_cnt, ifa.pad_neg_cnt};
    n_vec++;
    if (got !== 10'd0) begin
      n_err++; $display("FAIL reset_outputs got=%b exp=%b", got, 10'd0);
    end
    n_vec++;
    if (ifa.cmd_ready !== 1'b1 || ifa.rd_data_ptr !== 2'd0) begin
      n_err++; $display("FAIL reset_ready_ptr got=%b/%0d exp=1/0", ifa.cmd_ready, ifa.rd_data_ptr);
    end
    n_vec++;
    if (ifb.cmd_ready !== 1'b1 || ifb.busy !== 1'b0) begin
      n_err++; $display("FAIL reset_b_ready got=%b/%b exp=1/0", ifb.cmd_ready, ifb.busy);
    end
  endtask

  task automatic test_bl4_write();
    logic [5:0] got, exp;
    do_reset();
    run_cmds(10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (acc_cyc[0] !== 0) begin
      n_err++; $display("FAIL bl4_wr_accept got=%0d exp=0", acc_cyc[0]);
    end
    for (int c = 0; c < 10; c++) begin
      exp = {(c >= 2 && c <= 5), (c >= 3 && c <= 4), (c == 0 || c >= 6), (c >= 1 && c <= 5), 1'b0, 1'b0};
      got = {tr_drv[c], tr_req[c], tr_rdy[c], tr_busy[c], tr_pad[c], tr_dqs[c]};
      n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL bl4_wr cyc=%0d got=%b exp=%b (drv,req,rdy,busy,pad,dqs)", c, got, exp);
      end
      n_vec++;
      if (tr_pos[c] !== 2'd0 || tr_neg[c] !== 2'd0) begin
        n_err++; $display("FAIL bl4_wr_ptr cyc=%0d got=%0d/%0d exp=0/0", c, tr_pos[c], tr_neg[c]);
      end
    end
  endtask

  task automatic test_bl8_read();
    logic [4:0] got, exp;
    logic [5:0] gp, ep;
    do_reset();
    run_cmds(14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 14; c++) begin
      exp = {(c >= 1 && c <= 8), (c >= 5 && c <= 8), (c >= 7 && c <= 10), (c == 0 || c >= 11), 1'b0};
      got = {tr_pad[c], tr_dqs[c], tr_vld[c], tr_rdy[c], tr_drv[c]};
      n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL bl8_rd cyc=%0d got=%b exp=%b (pad,dqs,vld,rdy,drv)", c, got, exp);
      end
      ep = {2'((c >= 5 && c <= 8) ? c - 5 : 0), 2'((c >= 6 && c <= 9) ? c - 6 : 0),
            2'((c >= 7 && c <= 10) ? c - 7 : 0)};
      gp = {tr_pos[c], tr_neg[c], tr_ptr[c]};
      n_vec++;
      if (gp !== ep) begin
        n_err++; $display("FAIL bl8_rd_ptr cyc=%0d got=%h exp=%h (pos,neg,ptr)", c, gp, ep);
      end
    end
  endtask

  task automatic test_read_then_write();
    logic [3:0] got, exp;
    do_reset();
    run_cmds(16, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (acc_cyc[1] !== 9) begin
      n_err++; $display("FAIL rd_wr_accept got=%0d exp=9", acc_cyc[1]);
    end
    for (int c = 0; c < 16; c++) begin
      exp = {(c >= 11 && c <= 14), (c >= 1 && c <= 6), (c >= 5 && c <= 6), (c == 0 || c == 9 || c == 15)};
      got = {tr_drv[c], tr_pad[c], tr_dqs[c], tr_rdy[c]};
      n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL rd_wr cyc=%0d got=%b exp=%b (drv,pad,dqs,rdy)", c, got, exp);
      end
      n_vec++;
      if (tr_pos[c] !== 2'((c <= 5) ? 0 : (c == 6) ? 1 : 2)) begin
        n_err++; $display("FAIL rd_wr_pos cyc=%0d got=%0d", c, tr_pos[c]);
      end
    end
  endtask

  task automatic test_write_then_read();
    logic [1:0] got, exp;
    do_reset();
    run_cmds(20, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (acc_cyc[1] !== 8) begin
      n_err++; $display("FAIL wr_rd_accept got=%0d exp=8", acc_cyc[1]);
    end
    for (int c = 0; c < 20; c++) begin
      exp = {(c >= 2 && c <= 7), (c >= 9 && c <= 14)};
      got = {tr_drv[c], tr_pad[c]};
      n_vec++;
      if (got !== exp || (tr_drv[c] && tr_pad[c])) begin
        n_err++; $display("FAIL wr_rd cyc=%0d got=%b exp=%b (drv,pad)", c, got, exp);
      end
    end
  endtask

  task automatic test_two_reads_turn0();
    int         exp_pos[11] = '{0, 0, 0, 1, 2, 2, 2, 3, 0, 0, 0};
    logic [2:0] got, exp;
    logic [5:0] gp, ep;
    int         prev;
    do_reset();
    ifb.cmd_valid = 1'b1; ifb.cmd_wr = 1'b0; ifb.burst_length_four = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      prev = (c == 0) ? 0 : exp_pos[c-1];
      exp = {(c == 2 || c == 3 || c == 6 || c == 7), (c == 3 || c == 4 || c == 7 || c == 8),
             (c == 0 || c == 4 || c >= 8)};
      got = {ifb.dqs_read, ifb.rd_data_valid, ifb.cmd_ready};
      n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL turn0 cyc=%0d got=%b exp=%b (dqs,vld,rdy)", c, got, exp);
      end
      ep = {2'(exp_pos[c]), 2'(prev), 2'(prev)};
      gp = {ifb.pad_pos_cnt, ifb.pad_neg_cnt, ifb.rd_data_ptr};
      n_vec++;
      if (gp !== ep) begin
        n_err++; $display("FAIL turn0_ptr cyc=%0d got=%h exp=%h (pos,neg,ptr)", c, gp, ep);
      end
      @(posedge clk);
      #1;
      if (c == 4) ifb.cmd_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [11:0] got;
    do_reset();
    ifa.cmd_valid = 1'b1; ifa.cmd_wr = 1'b0; ifa.burst_length_four = 1'b0;
    @(posedge clk);
    #1 ifa.cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_vec++;
    if (ifa.dqs_read !== 1'b1 || ifa.pad_pos_cnt !== 2'd1) begin
      n_err++; $display("FAIL midrst_pre got=%b/%0d exp=1/1", ifa.dqs_read, ifa.pad_pos_cnt);
    end
    arst = 1'b1;
    #1;
    got = {ifa.dram_io_drive_enable, ifa.dram_io_pad_enable, ifa.dqs_read, ifa.wr_data_req,
           ifa.rd_data_valid, ifa.busy, ifa.pad_pos_cnt, ifa.pad_neg_cnt, ifa.rd_data_ptr};
    n_vec++;
    if (got !== 12'd0 || ifa.cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_now got=%b rdy=%b exp=0 rdy=1", got, ifa.cmd_ready);
    end
    @(posedge clk);
    @(posedge clk);
    #1 arst = 1'b0;
    @(negedge clk);
    got = {ifa.dram_io_drive_enable, ifa.dram_io_pad_enable, ifa.dqs_read, ifa.wr_data_req,
           ifa.rd_data_valid, ifa.busy, ifa.pad_pos_cnt, ifa.pad_neg_cnt, ifa.rd_data_ptr};
    n_vec++;
    if (got !== 12'd0 || ifa.cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_release got=%b rdy=%b exp=0 rdy=1", got, ifa.cmd_ready);
    end
    @(posedge clk);
    #1;
    run_cmds(12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (tr_dqs[5] !== 1'b1 || tr_pos[5] !== 2'd0 || tr_pos[8] !== 2'd3) begin
      n_err++; $display("FAIL midrst_next_pos got=%b/%0d/%0d exp=1/0/3", tr_dqs[5], tr_pos[5], tr_pos[8]);
    end
    n_vec++;
    if (tr_vld[7] !== 1'b1 || tr_ptr[7] !== 2'd0) begin
      n_err++; $display("FAIL midrst_next_ptr got=%b/%0d exp=1/0", tr_vld[7], tr_ptr[7]);
    end
  endtask

  task automatic test_bl_toggle();
    logic [2:0] got, exp;
    int         nd;
    do_reset();
    run_cmds(10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      exp = {(c >= 2 && c <= 5), (c >= 3 && c <= 4), 1'b0};
      got = {tr_drv[c], tr_req[c], tr_pad[c]};
      n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL toggle_wr cyc=%0d got=%b exp=%b (drv,req,pad)", c, got, exp);
      end
    end
    run_cmds(14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    nd = 0;
    for (int c = 0; c < 14; c++) nd += int'(tr_dqs[c]);
    n_vec++;
    if (nd !== 4 || tr_dqs[5] !== 1'b1 || tr_dqs[8] !== 1'b1) begin
      n_err++; $display("FAIL toggle_rd dqs_cycles got=%0d exp=4", nd);
    end
  endtask

  task automatic test_random();
    int          idle_from, n;
    bit          v, wr, bl, rdy;
    logic [12:0] got, exp;
    logic [1:0]  e_neg, e_ptr;
    bit          e_vld;
    do_reset();
    for (int i = 0; i < MAXC; i++) begin
      m_drv[i] = 1'b0; m_req[i] = 1'b0; m_pad[i] = 1'b0; m_dqs[i] = 1'b0; m_pos[i] = 0;
    end
    idle_from = 0;
    for (int k = 0; k < NR; k++) begin
      v  = ($urandom_range(0, 2) == 0);
      wr = 1'($urandom_range(0, 1));
      bl = 1'($urandom_range(0, 1));
      ifa.cmd_valid = v; ifa.cmd_wr = wr; ifa.burst_length_four = bl;
      rdy = (k >= idle_from);
      if (v && rdy) begin
        n = bl ? 2 : 4;
        if (wr) begin
          for (int c = k + A_WR; c <= k + A_WR + n + 1; c++) m_drv[c] = 1'b1;
          for (int c = k + A_WR + 1; c <= k + A_WR + n; c++) m_req[c] = 1'b1;
          idle_from = k + A_WR + n + 2;
        end else begin
          for (int c = k + 1; c <= k + A_RD + n; c++) m_pad[c] = 1'b1;
          for (int c = k + A_RD + 1; c <= k + A_RD + n; c++) m_dqs[c] = 1'b1;
          idle_from = k + A_RD + n + A_TURN + 1;
        end
      end
      m_pos[k] = (k == 0) ? 0 : (m_pos[k-1] + int'(m_dqs[k-1])) % 4;
      e_neg = (k == 0) ? 2'd0 : 2'(m_pos[k-1]);
      e_vld = (k >= A_D) ? m_dqs[k-A_D] : 1'b0;
      e_ptr = (k >= A_D) ? 2'(m_pos[k-A_D]) : 2'd0;
      @(negedge clk);
      exp = {rdy, !rdy, m_drv[k], m_req[k], m_pad[k], m_dqs[k], e_vld, 2'(m_pos[k]), e_neg, e_ptr};
      got = {ifa.cmd_ready, ifa.busy, ifa.dram_io_drive_enable, ifa.wr_data_req, ifa.dram_io_pad_enable,
             ifa.dqs_read, ifa.rd_data_valid, ifa.pad_pos_cnt, ifa.pad_neg_cnt, ifa.rd_data_ptr};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL random cyc=%0d got=%b exp=%b (rdy,busy,drv,req,pad,dqs,vld,pos,neg,ptr)", k, got, exp);
      end
      @(posedge clk);
      #1;
    end
    ifa.cmd_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_bl4_write();
    test_bl8_read();
    test_read_then_write();
    test_write_then_read();
    test_two_reads_turn0();
    test_reset_mid_burst();
    test_bl_toggle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
